// File: rtl/tx_pattern_gen_pkg.sv
// Shared types and helpers for the transmit pattern generator: mode encoding,
// PAM5 level mapping, constant-level saturation, ramp levels and PRBS seeds.
package tx_pattern_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_PRBS  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_RAMP  = 2'd3
    } mode_t;

    typedef logic signed [2:0] level_t;

    // Packed so that LANE_SEED[i] is the seed of lane i.
    localparam logic [LANES-1:0][14:0] LANE_SEED = {15'h0200, 15'h0040, 15'h0008, 15'h0001};

    function automatic level_t pam5_level(input logic [2:0] idx);
        level_t lvl;
        case (idx)
            3'd0:    lvl = -3'sd2;
            3'd1:    lvl = -3'sd1;
            3'd2:    lvl = 3'sd0;
            3'd3:    lvl = 3'sd1;
            3'd4:    lvl = 3'sd2;
            3'd5:    lvl = -3'sd1;
            3'd6:    lvl = 3'sd0;
            default: lvl = 3'sd1;
        endcase
        return lvl;
    endfunction

    function automatic level_t sat_level(input level_t raw);
        level_t lvl;
        if (raw < -3'sd2) begin
            lvl = -3'sd2;
        end else if (raw > 3'sd2) begin
            lvl = 3'sd2;
        end else begin
            lvl = raw;
        end
        return lvl;
    endfunction

    // phase is 0..4 and lane 0..3, so the sum never exceeds 7 and one fold covers mod 5.
    function automatic level_t ramp_level(input logic [2:0] phase, input logic [1:0] lane);
        logic [2:0] sum;
        level_t     lvl;
        sum = phase + {1'b0, lane};
        case (sum)
            3'd0, 3'd5: lvl = -3'sd2;
            3'd1, 3'd6: lvl = -3'sd1;
            3'd2, 3'd7: lvl = 3'sd0;
            3'd3:       lvl = 3'sd1;
            default:    lvl = 3'sd2;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/tx_pattern_gen_if.sv
// Control and sample bus between the pattern generator and its consumer (FFE input side).
interface tx_pattern_gen_if #(
    parameter int WIDTH = 8
);
    logic                    io_start;
    logic                    io_stop;
    logic [1:0]              io_mode;
    logic [15:0]             io_burst_len;
    logic [2:0]              io_const_level;
    logic                    io_out_valid;
    logic signed [WIDTH-1:0] io_out_bits_0;
    logic signed [WIDTH-1:0] io_out_bits_1;
    logic signed [WIDTH-1:0] io_out_bits_2;
    logic signed [WIDTH-1:0] io_out_bits_3;
    logic                    io_busy;
    logic                    io_done;

    modport master (
        input  io_start, io_stop, io_mode, io_burst_len, io_const_level,
        output io_out_valid, io_out_bits_0, io_out_bits_1, io_out_bits_2, io_out_bits_3,
        output io_busy, io_done
    );

    modport slave (
        output io_start, io_stop, io_mode, io_burst_len, io_const_level,
        input  io_out_valid, io_out_bits_0, io_out_bits_1, io_out_bits_2, io_out_bits_3,
        input  io_busy, io_done
    );
endinterface

// File: rtl/tx_pattern_gen_prbs15_lane.sv
// One PRBS15 lane (x^15 + x^14 + 1, Fibonacci) stepping three bits per advance.
// idx reflects the three bits the next advance will produce; the first bit lands in idx[0].
module prbs15_lane #(
    parameter logic [14:0] SEED = 15'h0001
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       adv,
    output logic [2:0] idx
);
    logic [14:0] lfsr;
    logic [14:0] base;
    logic [14:0] stepped;

    // A load restarts from the seed in the same cycle, so the first sample needs no warm-up cycle.
    always_comb begin
        base    = load ? SEED : lfsr;
        stepped = base;
        idx     = '0;
        for (int k = 0; k < 3; k++) begin
            idx[k]  = stepped[14] ^ stepped[13];
            stepped = {stepped[13:0], idx[k]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (load || adv) begin
            lfsr <= stepped;
        end
    end
endmodule

// File: rtl/tx_pattern_gen.sv
// Four-lane PAM5 stimulus source (PRBS / constant / ramp) feeding the FFE input,
// with finite or continuous bursts and fully registered outputs.
module tx_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int SCALE = 32,
    parameter int LANES = tx_pattern_pkg::LANES
) (
    input  logic            clock,
    input  logic            reset,
    tx_pattern_gen_if.master io
);
    import tx_pattern_pkg::*;

    if (2 * SCALE > 2 ** (WIDTH - 1) - 1) begin : g_scale_check
        $error("SCALE too large: 2*SCALE must fit in a signed WIDTH-bit sample");
    end
    if (LANES != 4) begin : g_lanes_check
        $error("LANES must be 4");
    end

    localparam logic signed [WIDTH-1:0] SCALE_S = WIDTH'(SCALE);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                  state, state_n;
    mode_t                   mode_q, mode_sel;
    logic [15:0]             len_q;
    level_t                  lvl_q, lvl_sel;
    logic [15:0]             cnt, cnt_base;
    logic [2:0]              phase, phase_base;
    logic                    start_ok, emit, done_n;
    logic                    valid_q, done_q;
    logic [2:0]              prbs_idx [LANES];
    level_t                  lane_lvl [LANES];
    logic signed [WIDTH-1:0] sample_n [LANES];
    logic signed [WIDTH-1:0] bits_q   [LANES];

    function automatic logic signed [WIDTH-1:0] scale_level(input level_t lvl);
        logic signed [WIDTH-1:0] wide;
        wide = WIDTH'(lvl);
        return wide * SCALE_S;
    endfunction

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        prbs15_lane #(
            .SEED (LANE_SEED[g])
        ) u_prbs (
            .clock (clock),
            .reset (reset),
            .load  (start_ok),
            .adv   (emit),
            .idx   (prbs_idx[g])
        );
    end

    always_comb begin
        state_n  = state;
        start_ok = 1'b0;
        emit     = 1'b0;
        done_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (io.io_start && !io.io_stop && io.io_mode != 2'd0) begin
                    start_ok = 1'b1;
                    emit     = 1'b1;
                    state_n  = S_RUN;
                end
            end
            default: begin
                // Stop wins over a burst that would complete in the same cycle.
                if (io.io_stop) begin
                    state_n = S_IDLE;
                end else if (len_q != 16'd0 && cnt == len_q) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
        endcase
    end

    // The start cycle already registers the first sample, so it reads the live inputs.
    always_comb begin
        mode_sel   = start_ok ? mode_t'(io.io_mode) : mode_q;
        lvl_sel    = start_ok ? sat_level(level_t'(io.io_const_level)) : lvl_q;
        cnt_base   = start_ok ? 16'd0 : cnt;
        phase_base = start_ok ? 3'd0 : phase;
        for (int l = 0; l < LANES; l++) begin
            case (mode_sel)
                MODE_PRBS:  lane_lvl[l] = pam5_level(prbs_idx[l]);
                MODE_CONST: lane_lvl[l] = lvl_sel;
                MODE_RAMP:  lane_lvl[l] = ramp_level(phase_base, 2'(l));
                default:    lane_lvl[l] = 3'sd0;
            endcase
            sample_n[l] = emit ? scale_level(lane_lvl[l]) : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            mode_q  <= MODE_IDLE;
            len_q   <= '0;
            lvl_q   <= '0;
            cnt     <= '0;
            phase   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                bits_q[l] <= '0;
            end
        end else begin
            state   <= state_n;
            valid_q <= emit;
            done_q  <= done_n;
            for (int l = 0; l < LANES; l++) begin
                bits_q[l] <= sample_n[l];
            end
            if (start_ok) begin
                mode_q <= mode_sel;
                len_q  <= io.io_burst_len;
                lvl_q  <= lvl_sel;
            end
            if (emit) begin
                cnt   <= cnt_base + 16'd1;
                phase <= (phase_base == 3'd4) ? 3'd0 : phase_base + 3'd1;
            end
        end
    end

    assign io.io_out_valid  = valid_q;
    assign io.io_out_bits_0 = bits_q[0];
    assign io.io_out_bits_1 = bits_q[1];
    assign io.io_out_bits_2 = bits_q[2];
    assign io.io_out_bits_3 = bits_q[3];
    assign io.io_busy       = (state == S_RUN);
    assign io.io_done       = done_q;
endmodule

// File: tb/tb_tx_pattern_gen.sv
// Directed bench for tx_pattern_gen: constant, PRBS, ramp, saturation, stop/reset handling.
module tb_tx_pattern_gen;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    tx_pattern_gen_if #(.WIDTH(8)) bus ();

    tx_pattern_gen #(
        .WIDTH (8),
        .SCALE (32),
        .LANES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic signed [7:0] lane_out [4];
    assign lane_out[0] = bus.io_out_bits_0;
    assign lane_out[1] = bus.io_out_bits_1;
    assign lane_out[2] = bus.io_out_bits_2;
    assign lane_out[3] = bus.io_out_bits_3;

    logic [14:0] mdl  [4];
    int          mexp [4];
    int          lut  [8] = '{-2, -1, 0, 1, 2, -1, 0, 1};
    string       ptag [4] = '{"prbs_l0", "prbs_l1", "prbs_l2", "prbs_l3"};
    int          ramp_l0 [6] = '{-64, -32, 0, 32, 64, -64};
    int          ramp_l3 [6] = '{32, 64, -64, -32, 0, 32};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, bus.io_out_valid, 0);
        chk({tag, "_busy"}, bus.io_busy, 0);
        chk({tag, "_done"}, bus.io_done, 0);
        for (int l = 0; l < 4; l++) chk({tag, "_bits"}, lane_out[l], 0);
    endtask

    task automatic chk_all_lanes(input string tag, input int exp);
        for (int l = 0; l < 4; l++) chk(tag, lane_out[l], exp);
    endtask

    task automatic model_seed();
        mdl[0] = 15'h0001;
        mdl[1] = 15'h0008;
        mdl[2] = 15'h0040;
        mdl[3] = 15'h0200;
    endtask

    // Bit-serial golden model: three feedback bits per sample, first bit is index bit 0.
    task automatic chk_prbs();
        for (int l = 0; l < 4; l++) begin
            logic [2:0] ix;
            logic       fb;
            for (int j = 0; j < 3; j++) begin
                fb     = mdl[l][14] ^ mdl[l][13];
                mdl[l] = {mdl[l][13:0], fb};
                ix[j]  = fb;
            end
            mexp[l] = lut[ix] * 32;
            chk(ptag[l], lane_out[l], mexp[l]);
        end
    endtask

    task automatic pulse_start(input logic [1:0] mode, input logic [15:0] len, input logic [2:0] lvl);
        bus.io_mode        = mode;
        bus.io_burst_len   = len;
        bus.io_const_level = lvl;
        bus.io_start       = 1'b1;
        tick();
        bus.io_start       = 1'b0;
        bus.io_mode        = 2'd0;
        bus.io_burst_len   = 16'd0;
        bus.io_const_level = 3'd0;
    endtask

    initial begin
        bus.io_start       = 1'b0;
        bus.io_stop        = 1'b0;
        bus.io_mode        = 2'd0;
        bus.io_burst_len   = 16'd0;
        bus.io_const_level = 3'd0;
        repeat (3) tick();
        chk_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // mode 0 start and start+stop together are both ignored in IDLE
        pulse_start(2'd0, 16'd3, 3'd1);
        chk_idle_outputs("start_mode0");
        bus.io_stop = 1'b1;
        pulse_start(2'd2, 16'd3, 3'd1);
        bus.io_stop = 1'b0;
        chk_idle_outputs("start_with_stop");

        // CONST +1, three samples then done
        pulse_start(2'd2, 16'd3, 3'd1);
        for (int k = 0; k < 3; k++) begin
            chk("const_valid", bus.io_out_valid, 1);
            chk("const_busy", bus.io_busy, 1);
            chk("const_done_early", bus.io_done, 0);
            chk_all_lanes("const_p1", 32);
            tick();
        end
        chk("const_end_valid", bus.io_out_valid, 0);
        chk("const_end_done", bus.io_done, 1);
        chk("const_end_busy", bus.io_busy, 0);
        chk("const_end_bits", lane_out[0], 0);
        tick();
        chk("const_done_pulse", bus.io_done, 0);

        // PRBS short burst: lane0 starts at index 0 -> -64
        pulse_start(2'd1, 16'd4, 3'd0);
        model_seed();
        for (int k = 0; k < 4; k++) begin
            chk("prbs4_lane0_const", lane_out[0], -64);
            chk_prbs();
            tick();
        end
        chk("prbs4_done", bus.io_done, 1);
        chk("prbs4_valid", bus.io_out_valid, 0);

        // PRBS long burst against the golden model
        tick();
        pulse_start(2'd1, 16'd10000, 3'd0);
        model_seed();
        for (int k = 0; k < 10000; k++) begin
            chk("prbs10k_valid", bus.io_out_valid, 1);
            chk_prbs();
            tick();
        end
        chk("prbs10k_done", bus.io_done, 1);
        chk("prbs10k_valid_end", bus.io_out_valid, 0);

        // RAMP
        tick();
        pulse_start(2'd3, 16'd6, 3'd0);
        for (int k = 0; k < 6; k++) begin
            chk("ramp_l0", lane_out[0], ramp_l0[k]);
            chk("ramp_l3", lane_out[3], ramp_l3[k]);
            tick();
        end
        chk("ramp_done", bus.io_done, 1);

        // CONST saturation
        tick();
        pulse_start(2'd2, 16'd1, 3'b100);
        chk_all_lanes("const_m4", -64);
        tick();
        chk("const_m4_done", bus.io_done, 1);
        tick();
        pulse_start(2'd2, 16'd1, 3'd3);
        chk_all_lanes("const_p3", 64);
        tick();
        chk("const_p3_done", bus.io_done, 1);

        // stop in the same cycle the burst would complete: no done
        tick();
        pulse_start(2'd2, 16'd2, 3'd2);
        chk("stopprio_s1", lane_out[0], 64);
        tick();
        chk("stopprio_s2", lane_out[0], 64);
        bus.io_stop = 1'b1;
        tick();
        bus.io_stop = 1'b0;
        chk_idle_outputs("stopprio");

        // continuous PRBS past the 16-bit counter wrap, with an ignored start, then stop
        pulse_start(2'd1, 16'd0, 3'd0);
        model_seed();
        for (int k = 0; k < 70000; k++) begin
            chk("cont_valid", bus.io_out_valid, 1);
            chk("cont_done", bus.io_done, 0);
            chk_prbs();
            if (k == 100) begin
                bus.io_start       = 1'b1;
                bus.io_mode        = 2'd2;
                bus.io_burst_len   = 16'd5;
                bus.io_const_level = 3'd1;
            end
            if (k == 101) begin
                bus.io_start       = 1'b0;
                bus.io_mode        = 2'd0;
                bus.io_burst_len   = 16'd0;
                bus.io_const_level = 3'd0;
            end
            if (k == 69999) bus.io_stop = 1'b1;
            tick();
        end
        bus.io_stop = 1'b0;
        chk_idle_outputs("cont_stop");
        tick();
        chk("cont_stop_nodone", bus.io_done, 0);

        // reset mid-burst, then the sequence restarts from the seeds
        pulse_start(2'd1, 16'd0, 3'd0);
        repeat (5) tick();
        chk("midreset_busy_before", bus.io_busy, 1);
        reset = 1'b1;
        tick();
        chk_idle_outputs("midreset");
        reset = 1'b0;
        pulse_start(2'd1, 16'd20, 3'd0);
        model_seed();
        for (int k = 0; k < 20; k++) begin
            chk_prbs();
            tick();
        end
        chk("midreset_done", bus.io_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_pattern_gen.md
Name: tx_pattern_gen

Overview:
- Hardware stimulus source that sits directly upstream of the FFE in the base-T transmit encode path.
- Produces four lanes of signed PAM5 symbols, scaled to the FFE input width, with a valid strobe. The interface matches the FFE input: io_in_valid, io_in_bits_0..3.
- Replaces file-driven stimulus for on-chip bring-up and BIST. Modes: PRBS, constant, ramp. Bursts are finite or continuous.

Parameters:
- WIDTH, 8, output sample width (signed two's complement).
- SCALE, 32, amplitude per PAM5 level; output = level*SCALE. Elaboration fails unless 2*SCALE <= 2^(WIDTH-1)-1.
- LANES, 4, number of lanes; fixed at 4, ports are enumerated.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- io_start  in  1  one-cycle pulse; begins a burst
- io_stop  in  1  one-cycle pulse; aborts a running burst
- io_mode  in  2  0 IDLE, 1 PRBS, 2 CONST, 3 RAMP; sampled at start
- io_burst_len  in  16  number of samples; 0 = continuous; sampled at start
- io_const_level  in  3  signed level for CONST mode; sampled at start
- io_out_valid  out  1  sample valid, feeds FFE io_in_valid
- io_out_bits_0..3  out  WIDTH each  signed lane samples
- io_busy  out  1  high in RUN
- io_done  out  1  one-cycle pulse at normal burst completion

Behaviour:
- Reset values: state IDLE; io_out_valid=0; io_out_bits_*=0; io_busy=0; io_done=0; counters=0; LFSRs loaded with seeds.
- State machine has two states, IDLE and RUN.
- IDLE -> RUN:
  - Requires io_start=1, io_stop=0 and io_mode!=0.
  - Latches mode, burst_len and const_level.
  - Reseeds all LFSRs and clears the sample counter.
  - io_start with mode 0 is ignored.
- RUN: one sample per cycle, io_out_valid=1 every cycle.
  - First valid sample appears on the cycle after the start pulse. All outputs are registered.
- RUN -> IDLE, normal end:
  - Occurs after exactly burst_len valid samples when burst_len != 0.
  - io_done pulses on the first cycle after the last valid sample; io_out_valid=0 on that cycle.
- RUN -> IDLE, abort:
  - Triggered by io_stop in RUN. io_stop has priority over burst completion in the same cycle.
  - io_out_valid=0 from the next cycle; no io_done.
- Start and stop interaction:
  - io_start while in RUN is ignored.
  - io_start and io_stop together in IDLE are ignored.
- When io_out_valid=0, io_out_bits_* are driven to 0.
- PRBS mode:
  - Each lane has its own PRBS15, Fibonacci form, s' = {s[13:0], s[14]^s[13]}.
  - Each lane advances 3 steps per valid cycle. The new bits in order form index {b2,b1,b0}.
  - Seeds: lane0 15'h0001, lane1 15'h0008, lane2 15'h0040, lane3 15'h0200.
  - Level LUT: 0->-2, 1->-1, 2->0, 3->+1, 4->+2, 5->-1, 6->0, 7->+1.
- CONST mode:
  - All lanes output const_level*SCALE.
  - const_level is saturated to [-2,+2]: -4 and -3 -> -2; +3 -> +2.
- RAMP mode:
  - Lane i outputs level ((cnt+i) mod 5) - 2, where cnt starts at 0 and increments per valid sample.
  - cnt wraps 4->0 without overflow.
- Sample counter and continuous bursts:
  - Sample counter is 16 bits.
  - With burst_len=0 there is no completion; cnt wraps freely and the burst runs until stop.
- Reset asserted mid-burst returns to reset values on the next edge.
- Multiplication by SCALE yields an exact WIDTH-bit result; no truncation is permitted.

Decomposition:
- Shared package tx_pattern_pkg:
  - mode enum (IDLE/PRBS/CONST/RAMP)
  - PAM5 level LUT function
  - level saturation function
  - lane seed constants
  - LANES constant
- One sub-module, prbs15_lane: seedable PRBS15 that advances 3 steps per enable and outputs the 3-bit index. Instantiated 4 times.

Test Plan:
- Reset, then start with mode=CONST, const_level=+1, burst_len=3:
  - valid high exactly 3 cycles beginning the cycle after start, all lanes 32 (0x20);
  - done pulses on the next cycle; busy drops with it.
- Start with mode=PRBS, burst_len=4:
  - lane0 index sequence starts 0,0,0,0 -> samples -64 (0xC0);
  - all lanes match a golden PRBS15 model over 10000 samples in a second run with burst_len=10000.
- Start with mode=RAMP, burst_len=6:
  - lane0 = -64,-32,0,32,64,-64;
  - lane3 = 32,64,-64,-32,0,32.
- Start with mode=CONST, const_level=-4 -> all lanes -64; const_level=3 -> all lanes +64.
- Start with mode=PRBS, burst_len=0:
  - runs 70000 cycles with no done and cnt wraps;
  - io_stop -> valid low next cycle, no done; io_start while busy has no effect.
- Reset asserted mid-burst:
  - outputs zero, busy low next edge;
  - a fresh start reproduces the identical PRBS sequence from the seeds.
